// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: execute stage with ALU, branch resolution and a single output register.
// Defining EX_STAGE_MUL_EN adds a serial shift-add multiplier (op 11) and MUL/DONE states.
// Without that macro op 11 is treated as illegal.
module ex_stage_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RA_W  = 5,
  parameter int unsigned IMM_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [IMM_W-1:0] imm,
  input  logic [XLEN-1:0] npc,
  input  logic [RA_W-1:0] rd,
  input  logic [3:0]      ctl,
  input  logic [1:0]      br,
  output logic            out_valid,
  input  logic            out_stall,
  output logic [XLEN-1:0] alu_out,
  output logic            br_taken,
  output logic [XLEN-1:0] bt,
  output logic [RA_W-1:0] out_rd,
  output logic [3:0]      out_ctl,
  output logic            err
);

  localparam int unsigned SH_W = $clog2(XLEN);

  logic [SH_W-1:0] shamt;
  logic [XLEN-1:0] alu_res;
  logic            illegal;
  logic            br_c;
  logic [XLEN-1:0] bt_c;
  logic [XLEN-1:0] imm_ext;
  logic            out_free;
  logic            idle;
  logic            accept;
  logic            is_mul;
  logic            load_single;

  assign shamt   = b[SH_W-1:0];
  assign imm_ext = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
  assign bt_c    = npc + (imm_ext << 2);
  assign br_c    = ((br == 2'b01) && (a == b)) || ((br == 2'b10) && (a != b));

  // Single-cycle ALU result and illegal-op decode
  always_comb begin
    alu_res = '0;
    illegal = 1'b0;
    case (op)
      4'd0:  alu_res = a + b;
      4'd1:  alu_res = a - b;
      4'd2:  alu_res = a & b;
      4'd3:  alu_res = a | b;
      4'd4:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd5:  alu_res = {{(XLEN-1){1'b0}}, (a < b)};
      4'd6:  alu_res = a ^ b;
      4'd7:  alu_res = ~(a | b);
      4'd8:  alu_res = a << shamt;
      4'd9:  alu_res = a >> shamt;
      4'd10: alu_res = $unsigned($signed(a) >>> shamt);
`ifdef EX_STAGE_MUL_EN
      4'd11: alu_res = '0;  // result comes from the serial multiplier
`else
      4'd11: illegal = 1'b1;
`endif
      default: illegal = 1'b1;
    endcase
  end

  assign out_free    = !out_valid || !out_stall;
  assign in_ready    = idle && out_free;
  assign accept      = in_valid && in_ready;
  assign load_single = accept && !is_mul;

`ifdef EX_STAGE_MUL_EN
  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e          state_q;
  logic [XLEN-1:0] mcand_q;
  logic [XLEN-1:0] mplier_q;
  logic [XLEN-1:0] prod_q;
  logic [SH_W-1:0] cnt_q;
  logic            l_taken_q;
  logic [XLEN-1:0] l_bt_q;
  logic [RA_W-1:0] l_rd_q;
  logic [3:0]      l_ctl_q;
  logic            load_mul;

  assign idle     = (state_q == StIdle);
  assign is_mul   = (op == 4'd11);
  assign load_mul = (state_q == StDone) && out_free;

  // Multiply FSM: latch operation at acceptance, one multiplier bit per MUL cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
      l_taken_q <= 1'b0;
      l_bt_q    <= '0;
      l_rd_q    <= '0;
      l_ctl_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept && is_mul) begin
            state_q   <= StMul;
            mcand_q   <= a;
            mplier_q  <= b;
            prod_q    <= '0;
            cnt_q     <= '0;
            l_taken_q <= br_c;
            l_bt_q    <= bt_c;
            l_rd_q    <= rd;
            l_ctl_q   <= ctl;
          end
        end
        StMul: begin
          prod_q   <= prod_q + (mplier_q[0] ? mcand_q : '0);
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + SH_W'(1);
          if (cnt_q == SH_W'(XLEN - 1)) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          if (out_free) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
`else
  assign idle   = 1'b1;
  assign is_mul = 1'b0;
`endif

  // Output register: loaded by single-cycle ops or finished multiply, held while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      alu_out   <= '0;
      br_taken  <= 1'b0;
      bt        <= '0;
      out_rd    <= '0;
      out_ctl   <= '0;
      err       <= 1'b0;
    end else begin
      if (accept && illegal) begin
        err <= 1'b1;
      end
      if (load_single) begin
        out_valid <= 1'b1;
        alu_out   <= alu_res;
        br_taken  <= br_c;
        bt        <= bt_c;
        out_rd    <= rd;
        out_ctl   <= ctl;
      end
`ifdef EX_STAGE_MUL_EN
      else if (load_mul) begin
        out_valid <= 1'b1;
        alu_out   <= prod_q;
        br_taken  <= l_taken_q;
        bt        <= l_bt_q;
        out_rd    <= l_rd_q;
        out_ctl   <= l_ctl_q;
      end
`endif
      else if (out_valid && !out_stall) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Bench for ex_stage_pipe: behavioural model with output queue plus directed literal checks.
module tb_ex_stage_pipe;

`ifdef EX_STAGE_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [15:0] imm = '0;
  logic [31:0] npc = '0;
  logic [4:0]  rd = '0;
  logic [3:0]  ctl = '0;
  logic [1:0]  br = '0;
  logic        out_valid;
  logic        out_stall = 1'b0;
  logic [31:0] alu_out;
  logic        br_taken;
  logic [31:0] bt;
  logic [4:0]  out_rd;
  logic [3:0]  out_ctl;
  logic        err;

  ex_stage_pipe #(.XLEN(32), .RA_W(5), .IMM_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .imm(imm), .npc(npc), .rd(rd), .ctl(ctl), .br(br), .out_valid(out_valid),
    .out_stall(out_stall), .alu_out(alu_out), .br_taken(br_taken), .bt(bt), .out_rd(out_rd),
    .out_ctl(out_ctl), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic        taken;
    logic [31:0] bt;
    logic [4:0]  rd;
    logic [3:0]  ctl;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  logic m_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Result of an op from the plain arithmetic definitions
  function automatic logic [31:0] model_alu(input logic [3:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
    int unsigned sh;
    logic [31:0] ones;
    sh = y % 32;
    ones = 32'hFFFF_FFFF;
    case (o)
      4'd0: return x + y;
      4'd1: return x - y;
      4'd2: return x & y;
      4'd3: return x | y;
      4'd4: return ((x ^ 32'h8000_0000) < (y ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'd5: return (x < y) ? 32'd1 : 32'd0;
      4'd6: return x ^ y;
      4'd7: return ~(x | y);
      4'd8: return x << sh;
      4'd9: return x >> sh;
      4'd10: return (x >> sh) | ((x >= 32'h8000_0000) ? ~(ones >> sh) : 32'd0);
      4'd11: return MulEn ? x * y : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Compare every meaningful output cycle against the head of the expectation queue
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_valid: got out_valid=1 expected no pending result");
      end else begin
        chk("m_alu", alu_out, q[0].alu);
        chk("m_taken", {31'd0, br_taken}, {31'd0, q[0].taken});
        chk("m_bt", bt, q[0].bt);
        chk("m_rd", {27'd0, out_rd}, {27'd0, q[0].rd});
        chk("m_ctl", {28'd0, out_ctl}, {28'd0, q[0].ctl});
        chk("m_err", {31'd0, err}, {31'd0, q[0].err});
        if (!out_stall) void'(q.pop_front());
      end
    end
  end

  // Offer one operation, wait (bounded) for acceptance, record its expected result
  task automatic send(input logic [3:0] o, input logic [31:0] va, input logic [31:0] vb,
                      input logic [15:0] vi, input logic [31:0] vn, input logic [4:0] vr,
                      input logic [3:0] vc, input logic [1:0] vbr);
    exp_t e;
    bit   ok;
    logic signed [31:0] off;
    ok = 1'b0;
    op = o; a = va; b = vb; imm = vi; npc = vn; rd = vr; ctl = vc; br = vbr;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready=0 for 200 cycles expected acceptance");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (o >= 4'd12 || (o == 4'd11 && !MulEn)) m_err = 1'b1;
    off = $signed(vi);
    e.alu   = model_alu(o, va, vb);
    e.taken = (vbr == 2'b01 && va == vb) || (vbr == 2'b10 && va != vb);
    e.bt    = vn + off * 4;
    e.rd    = vr;
    e.ctl   = vc;
    e.err   = m_err;
    q.push_back(e);
    #1;
    in_valid = 1'b0;
    // scramble inputs so any missing latch shows up
    a = $urandom; b = $urandom; npc = $urandom; imm = 16'($urandom);
    rd = 5'($urandom); ctl = 4'($urandom); br = 2'($urandom); op = 4'($urandom);
  endtask

  initial begin
    int n;
    bit rdy_seen;
    logic [31:0] hold_bt;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_alu", alu_out, 32'd0);
    chk("rst_bt", bt, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rd_ctl", {23'd0, out_rd, out_ctl, br_taken}, 32'd0);
    rst = 1'b0;

    // accepted on the first edge after reset release
    send(4'd0, 32'hFFFF_FFFF, 32'd1, 16'd0, 32'h0, 5'd1, 4'hA, 2'b00);
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_wrap", alu_out, 32'd0);
    chk("add_rd", {27'd0, out_rd}, 32'd1);

    send(4'd10, 32'h8000_0000, 32'd4, 16'd0, 32'h0, 5'd2, 4'h1, 2'b00);
    chk("sra", alu_out, 32'hF800_0000);
    send(4'd9, 32'h8000_0000, 32'd4, 16'd0, 32'h0, 5'd3, 4'h2, 2'b00);
    chk("srl", alu_out, 32'h0800_0000);
    send(4'd5, 32'd1, 32'hFFFF_FFFF, 16'd0, 32'h0, 5'd4, 4'h3, 2'b00);
    chk("sltu", alu_out, 32'd1);
    send(4'd4, 32'd1, 32'hFFFF_FFFF, 16'd0, 32'h0, 5'd5, 4'h4, 2'b00);
    chk("slt", alu_out, 32'd0);

    // branch resolution and target
    send(4'd0, 32'd5, 32'd5, 16'hFFFF, 32'h100, 5'd6, 4'h5, 2'b01);
    chk("beq_taken", {31'd0, br_taken}, 32'd1);
    chk("beq_bt", bt, 32'h0000_00FC);
    send(4'd0, 32'd5, 32'd5, 16'hFFFF, 32'h100, 5'd7, 4'h6, 2'b10);
    chk("bne_taken", {31'd0, br_taken}, 32'd0);

    // model-only coverage of remaining ops, back to back
    send(4'd1, 32'd10, 32'd3, 16'h0004, 32'h200, 5'd8, 4'h7, 2'b10);
    send(4'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 16'h8000, 32'h0, 5'd9, 4'h8, 2'b11);
    send(4'd3, 32'hF0F0_1234, 32'h0FF0_FF00, 16'h7FFF, 32'h10, 5'd10, 4'h9, 2'b01);
    send(4'd6, 32'hDEAD_BEEF, 32'h1234_5678, 16'h0, 32'h0, 5'd11, 4'hB, 2'b00);
    send(4'd7, 32'hDEAD_BEEF, 32'h1234_5678, 16'h0, 32'h0, 5'd12, 4'hC, 2'b00);
    send(4'd8, 32'h0000_00FF, 32'h0000_0124, 16'h0, 32'h0, 5'd13, 4'hD, 2'b00);
    send(4'd4, 32'hFFFF_FFFE, 32'd3, 16'h0, 32'h0, 5'd14, 4'hE, 2'b00);

    // multiply
    send(4'd11, 32'd7, 32'hFFFF_FFFF, 16'h0010, 32'h40, 5'd15, 4'hF, 2'b10);
    if (MulEn) begin
      rdy_seen = 1'b0;
      n = 0;
      for (int i = 1; i <= 60; i++) begin
        @(posedge clk);
        #1;
        n = i;
        if (out_valid) break;
        if (in_ready) rdy_seen = 1'b1;
      end
      chk("mul_latency", n, 32'd33);
      chk("mul_ready_low", {31'd0, rdy_seen}, 32'd0);
      chk("mul_result", alu_out, 32'hFFFF_FFF9);
      chk("mul_bt", bt, 32'h0000_0080);
    end else begin
      chk("mul_illegal_err", {31'd0, err}, 32'd1);
      chk("mul_illegal_alu", alu_out, 32'd0);
    end

    // illegal op
    send(4'd13, 32'd9, 32'd9, 16'h0, 32'h0, 5'd16, 4'h0, 2'b00);
    chk("illegal_alu", alu_out, 32'd0);
    chk("illegal_err", {31'd0, err}, 32'd1);
    chk("illegal_valid", {31'd0, out_valid}, 32'd1);

    // downstream stall holds everything
    send(4'd0, 32'd3, 32'd4, 16'h0002, 32'h1000, 5'd17, 4'h3, 2'b01);
    out_stall = 1'b1;
    hold_bt = 32'h0000_1008;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("stall_alu", alu_out, 32'd7);
      chk("stall_bt", bt, hold_bt);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_ready", {31'd0, in_ready}, 32'd0);
    end
    out_stall = 1'b0;
    send(4'd1, 32'd10, 32'd3, 16'h0, 32'h0, 5'd18, 4'h4, 2'b00);
    chk("after_stall", alu_out, 32'd7);

    // reset during a multiply
    send(4'd11, 32'd3, 32'd5, 16'h0, 32'h0, 5'd19, 4'h5, 2'b00);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    m_err = 1'b0;
    #1;
    chk("mrst_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_alu", alu_out, 32'd0);
    chk("mrst_bt", bt, 32'd0);
    chk("mrst_misc", {22'd0, err, out_rd, out_ctl, br_taken}, 32'd0);
    chk("mrst_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(4'd0, 32'd5, 32'd6, 16'h0, 32'h0, 5'd20, 4'h6, 2'b00);
    chk("post_rst_add", alu_out, 32'd11);
    chk("post_rst_err", {31'd0, err}, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_stage_pipe.md
EX_STAGE_PIPE -- requirements
Module: ex_stage_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (>=8, power of 2).
REQ-002 SHALL have parameter RA_W, default 5, destination-register address width.
REQ-003 SHALL have parameter IMM_W, default 16, immediate width (< XLEN-2).
REQ-004 SHALL have these ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  upstream operation valid.
- in_ready  out  1  block accepts an operation this cycle.
- op  in  4  ALU operation code.
- a, b  in  XLEN  operands.
- imm  in  IMM_W  branch offset in words.
- npc  in  XLEN  next-PC of the operation.
- rd  in  RA_W  destination register.
- ctl  in  4  {MemtoReg, RegWrite, MemRead, MemWrite}, passed through.
- br  in  2  00 none, 01 beq, 10 bne, 11 reserved (no branch).
- out_valid  out  1  output register holds a result.
- out_stall  in  1  downstream hold.
- alu_out  out  XLEN  result.
- br_taken  out  1  branch resolved taken.
- bt  out  XLEN  branch target.
- out_rd  out  RA_W  registered rd.
- out_ctl  out  4  registered ctl.
- err  out  1  sticky illegal-op flag.

Function
REQ-005 SHALL accept an operation when in_valid && in_ready are both high at a rising clk edge.
REQ-006 SHALL drive in_ready = (state==IDLE) && (!out_valid || !out_stall), combinationally.
REQ-007 SHALL present single-cycle operations on out_valid one cycle after acceptance, with all out_* registered together.
REQ-008 SHALL hold every output unchanged while out_valid && out_stall.
REQ-009 SHALL clear out_valid on an edge where the output is consumed (out_valid && !out_stall) and no new operation completes.
REQ-010 SHALL support op codes: 0 add, 1 sub, 2 and, 3 or, 4 slt (signed), 5 sltu, 6 xor, 7 nor, 8 sll, 9 srl, 10 sra, 11 mul.
- Shift amount is b[$clog2(XLEN)-1:0].
- Arithmetic wraps modulo 2^XLEN.
- slt/sltu yield 1 or 0, zero-extended.
REQ-011 SHALL treat op 12-15 as illegal: alu_out=0, result still emitted, err set to 1 and kept until reset.
REQ-012 SHALL compute bt = npc + (sign-extended imm << 2), truncated to XLEN, for every operation.
REQ-013 SHALL set br_taken = (br==01 && a==b) || (br==10 && a!=b), independent of op.
REQ-014 SHALL implement states IDLE, MUL, DONE:
- IDLE->MUL on acceptance of op 11.
- MUL runs exactly XLEN cycles of shift-add, one multiplier bit per cycle.
- MUL->DONE after the XLEN-th cycle.
- DONE->IDLE when the result is loaded into the output register, which requires !out_valid || !out_stall.
REQ-015 SHALL produce the low XLEN bits of the a*b product for mul, with out_valid high XLEN+1 cycles after acceptance when not stalled.
REQ-016 SHALL keep in_ready low throughout MUL and DONE.
REQ-017 SHALL latch rd, ctl, br, npc, imm and operands at acceptance, so inputs may change during MUL.

Reset
REQ-018 SHALL, on rst high, immediately:
- force state=IDLE, aborting any multiply in progress;
- set out_valid, alu_out, br_taken, bt, out_rd, out_ctl and err to 0;
- discard the partial product.
REQ-019 SHALL accept an operation on the first rising edge after rst deasserts.

Configuration
REQ-020 SHALL compile the multiplier and MUL/DONE states only when macro EX_STAGE_MUL_EN is defined.
REQ-021 SHALL, without EX_STAGE_MUL_EN, treat op 11 as illegal per REQ-011 and never leave IDLE.

Verification
REQ-022 XLEN=32: add a=0xFFFFFFFF, b=1 -> alu_out=0, out_valid one cycle later.
REQ-023 sra a=0x80000000, b=4 -> 0xF8000000; srl -> 0x08000000; sltu a=1, b=0xFFFFFFFF -> 1; slt -> 0.
REQ-024 br=01, a=b=5, npc=0x100, imm=0xFFFF -> br_taken=1, bt=0xFC; br=10 with the same operands -> br_taken=0.
REQ-025 With EX_STAGE_MUL_EN: mul a=7, b=0xFFFFFFFF -> alu_out=0xFFFFFFF9 at cycle 33, in_ready low during cycles 1-33. Without the macro: err=1, alu_out=0.
REQ-026 out_stall held 3 cycles with out_valid=1 -> outputs stable, in_ready=0. Then release -> next queued operation is accepted.
REQ-027 rst asserted at MUL cycle 10 -> state IDLE, all outputs 0. A following add is accepted and completes normally.
